line_raster_engine: RTL and testbench
=====================================

# line_raster_engine

Bresenham line rasteriser that answers the system controller's line-drawing handshake. It takes one line command (two endpoints plus a colour) per start pulse and emits one framebuffer pixel write per clock. When the line is complete it raises a held finish level. It sits between the vertex buffer read path and the framebuffer write-port muxes.

## Interface
Parameters:
- FB_WIDTH, 320: framebuffer pixels per row.
- FB_HEIGHT, 240: framebuffer rows.
- COORD_W, 10: width of each unsigned endpoint coordinate.
- ADDR_W, 17: framebuffer address width.
- COLOR_W, 8: pixel data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high, global.
- line_reset  in  1  synchronous clear, driven by the controller's reset-line-drawing strobe.
- start  in  1  one-cycle command strobe.
- x0, y0, x1, y1  in  COORD_W each  endpoints, sampled on start.
- color  in  COLOR_W  pixel value, sampled on start.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  ADDR_W  write address, y*FB_WIDTH + x.
- fb_data  out  COLOR_W  write data.
- busy  out  1  a line is in progress.
- finish  out  1  line complete; held high until line_reset or an accepted start.

## Operation
- States: IDLE, DRAW, DONE.
- IDLE:
  - start → DRAW.
  - Latch cx=x0, cy=y0, ex=x1, ey=y1, colour.
  - dx=|x1−x0|, dy=−|y1−y0|, sx=(x1≥x0)?+1:−1, sy=(y1≥y0)?+1:−1, err=dx+dy.
- DRAW, each cycle:
  - Issue a write for (cx,cy).
  - If (cx,cy)==(ex,ey), go to DONE.
  - Otherwise e2=2·err.
  - If e2≥dy: cx+=sx and err+=dy.
  - If e2≤dx: cy+=sy and err+=dx.
  - Both updates apply in the same cycle when both conditions hold, so err += both terms.
- DONE: finish=1, busy=0. start → DRAW with a fresh latch; finish drops on the next cycle.
- Arithmetic:
  - err is signed COORD_W+2 bits; e2 is signed COORD_W+3 bits.
  - dx and dy are computed with sign extension; there is no overflow for any legal endpoints.
- Clipping: a point with cx≥FB_WIDTH or cy≥FB_HEIGHT produces fb_we=0 for that cycle. Stepping continues and the cycle count is unchanged.
- Pixel count is max(dx,|dy|)+1.
- Priority: reset > line_reset > start.
  - line_reset in any state: next state IDLE, with fb_we, busy and finish all 0.
  - start while in DRAW is ignored.
- Reset values: state IDLE; fb_we=0, fb_addr=0, fb_data=0, busy=0, finish=0.

## Timing
- Cycle k is the interval after clock edge k. start is high in cycle −1 and sampled at edge 0.
- busy is high from cycle 0 through the last write cycle.
- Outputs are registered. Point i (0-based) has fb_we/fb_addr/fb_data valid in cycle i+1.
- With N points, the last write is in cycle N and finish rises in cycle N+1. finish is never coincident with fb_we.
- A single-point line writes in cycle 1 and finishes in cycle 2.
- Mid-line line_reset or reset: no further writes occur after the edge that samples it. Any write already presented in that cycle is still committed.
- The controller's order of reset strobe, then start the next cycle, is legal: the start is accepted from IDLE.

## Structure
- Shared package pm_gfx_pkg holds:
  - FB_WIDTH, FB_HEIGHT, COORD_W, ADDR_W, COLOR_W;
  - the state encoding (IDLE=0, DRAW=1, DONE=2, 2 bits).
- Sub-module fb_addr_calc: combinational y*FB_WIDTH + x. For the default width it uses shift-add, (y<<8)+(y<<6)+x. It is reusable by the memory-clear block.

## Test plan
- Horizontal line (0,0)→(3,0), color 8'hE0:
  - fb_addr 0,1,2,3 in cycles 1–4, fb_data E0;
  - finish in cycle 5, busy low from cycle 5.
- Single point (5,5):
  - one write, addr 1605, in cycle 1;
  - finish in cycle 2.
- Reverse diagonal (3,3)→(0,0): addrs 963, 642, 321, 0 in cycles 1–4.
- Steep line (0,0)→(1,3): addrs 0, 320, 641, 961.
- Clip (318,0)→(321,0):
  - fb_we high only in cycles 1–2 (addrs 318, 319), low in cycles 3–4;
  - finish in cycle 5.
- Abort:
  - Line (0,0)→(9,0) with line_reset in cycle 3: no fb_we after cycle 3, finish stays 0, busy 0 from cycle 4.
  - Repeat with reset in place of line_reset: all outputs go to 0 immediately.
  - A start in cycle 4 after the line_reset abort draws correctly.

Source files
------------

// File: rtl/pm_gfx_pkg.sv
// Shared graphics-pipeline constants and the line engine state encoding.
package pm_gfx_pkg;

   // Framebuffer geometry and bus widths
   localparam int unsigned FB_WIDTH  = 320;
   localparam int unsigned FB_HEIGHT = 240;
   localparam int unsigned COORD_W   = 10;
   localparam int unsigned ADDR_W    = 17;
   localparam int unsigned COLOR_W   = 8;

   // Line engine control states
   localparam int unsigned STATE_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } line_state_e;

endpackage : pm_gfx_pkg

// File: rtl/fb_addr_calc.sv
// Linear framebuffer address: y*FB_WIDTH + x. Purely combinational; shared
// with the memory-clear block.
module fb_addr_calc #(
   parameter int unsigned FB_WIDTH = pm_gfx_pkg::FB_WIDTH,
   parameter int unsigned COORD_W  = pm_gfx_pkg::COORD_W,
   parameter int unsigned ADDR_W   = pm_gfx_pkg::ADDR_W
) (
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   output logic [ADDR_W-1:0]  addr_o
);

   // Wide enough for the largest y*FB_WIDTH + x without wrap
   localparam int unsigned SUM_W = COORD_W + $clog2(FB_WIDTH) + 1;

   logic [SUM_W-1:0] sum;

   generate
      if (FB_WIDTH == 320) begin : g_shift_add
         // 320 = 256 + 64, so the multiply collapses to two shifted adds
         always_comb sum = (SUM_W'(y_i) << 8) + (SUM_W'(y_i) << 6) + SUM_W'(x_i);
      end else begin : g_mult
         // Generic row stride
         always_comb sum = (SUM_W'(y_i) * SUM_W'(FB_WIDTH)) + SUM_W'(x_i);
      end
   endgenerate

   assign addr_o = ADDR_W'(sum);

endmodule : fb_addr_calc

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: one command per start strobe, one framebuffer
// write per clock, held finish level when the line is complete.
module line_raster_engine
   import pm_gfx_pkg::*;
#(
   parameter int unsigned FB_WIDTH  = pm_gfx_pkg::FB_WIDTH,
   parameter int unsigned FB_HEIGHT = pm_gfx_pkg::FB_HEIGHT,
   parameter int unsigned COORD_W   = pm_gfx_pkg::COORD_W,
   parameter int unsigned ADDR_W    = pm_gfx_pkg::ADDR_W,
   parameter int unsigned COLOR_W   = pm_gfx_pkg::COLOR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               line_reset,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COLOR_W-1:0] color,
   output logic               fb_we,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_data,
   output logic               busy,
   output logic               finish
);

   // Error term and its doubled form
   localparam int unsigned ERR_W = COORD_W + 2;
   localparam int unsigned E2_W  = COORD_W + 3;

   line_state_e               state_q;

   // Walk position, end point and colour of the active line
   logic [COORD_W-1:0]        cx_q;
   logic [COORD_W-1:0]        cy_q;
   logic [COORD_W-1:0]        ex_q;
   logic [COORD_W-1:0]        ey_q;
   logic [COLOR_W-1:0]        color_q;

   // Bresenham state: dx >= 0, dy <= 0, step directions as "negative" flags
   logic signed [ERR_W-1:0]   dx_q;
   logic signed [ERR_W-1:0]   dy_q;
   logic signed [ERR_W-1:0]   err_q;
   logic                      sx_neg_q;
   logic                      sy_neg_q;

   // Registered outputs
   logic                      fb_we_q;
   logic [ADDR_W-1:0]         fb_addr_q;
   logic [COLOR_W-1:0]        fb_data_q;
   logic                      busy_q;
   logic                      finish_q;

   // Setup terms derived from the raw command
   logic [COORD_W-1:0]        adx;
   logic [COORD_W-1:0]        ady;
   logic signed [ERR_W-1:0]   dx_init;
   logic signed [ERR_W-1:0]   dy_init;
   logic signed [ERR_W-1:0]   err_init;
   logic                      sx_neg_init;
   logic                      sy_neg_init;

   // Per-step terms
   logic signed [E2_W-1:0]    e2;
   logic signed [E2_W-1:0]    dx_ext;
   logic signed [E2_W-1:0]    dy_ext;
   logic                      step_x;
   logic                      step_y;
   logic [COORD_W-1:0]        cx_d;
   logic [COORD_W-1:0]        cy_d;
   logic signed [ERR_W-1:0]   err_d;
   logic                      at_end;
   logic                      on_screen;
   logic                      accept;
   logic [ADDR_W-1:0]         pix_addr;

   // Address of the current walk position
   fb_addr_calc #(
      .FB_WIDTH (FB_WIDTH),
      .COORD_W  (COORD_W),
      .ADDR_W   (ADDR_W)
   ) u_addr (
      .x_i    (cx_q),
      .y_i    (cy_q),
      .addr_o (pix_addr)
   );

   // Command setup: absolute deltas, directions and initial error
   always_comb begin
      sx_neg_init = (x1 < x0);
      sy_neg_init = (y1 < y0);
      adx         = sx_neg_init ? (x0 - x1) : (x1 - x0);
      ady         = sy_neg_init ? (y0 - y1) : (y1 - y0);
      dx_init     = $signed(ERR_W'(adx));
      dy_init     = -$signed(ERR_W'(ady));
      err_init    = dx_init + dy_init;
   end

   // One Bresenham step; both axes may advance in the same cycle
   always_comb begin
      e2     = {err_q[ERR_W-1], err_q, 1'b0};
      dx_ext = {dx_q[ERR_W-1], dx_q};
      dy_ext = {dy_q[ERR_W-1], dy_q};
      step_x = (e2 >= dy_ext);
      step_y = (e2 <= dx_ext);

      err_d = err_q;
      if (step_x) err_d = err_d + dy_q;
      if (step_y) err_d = err_d + dx_q;

      cx_d = cx_q;
      if (step_x) cx_d = sx_neg_q ? (cx_q - COORD_W'(1)) : (cx_q + COORD_W'(1));

      cy_d = cy_q;
      if (step_y) cy_d = sy_neg_q ? (cy_q - COORD_W'(1)) : (cy_q + COORD_W'(1));

      at_end    = (cx_q == ex_q) && (cy_q == ey_q);
      on_screen = (32'(cx_q) < FB_WIDTH) && (32'(cy_q) < FB_HEIGHT);
      accept    = start && ((state_q == IDLE) || (state_q == DONE));
   end

   // Datapath: latch a new command or advance the walk while drawing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cx_q     <= '0;
         cy_q     <= '0;
         ex_q     <= '0;
         ey_q     <= '0;
         color_q  <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         err_q    <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
      end else if (!line_reset) begin
         if (accept) begin
            cx_q     <= x0;
            cy_q     <= y0;
            ex_q     <= x1;
            ey_q     <= y1;
            color_q  <= color;
            dx_q     <= dx_init;
            dy_q     <= dy_init;
            err_q    <= err_init;
            sx_neg_q <= sx_neg_init;
            sy_neg_q <= sy_neg_init;
         end else if ((state_q == DRAW) && !at_end) begin
            cx_q  <= cx_d;
            cy_q  <= cy_d;
            err_q <= err_d;
         end
      end
   end

   // Control FSM with registered handshake and write-port outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
         busy_q    <= 1'b0;
         finish_q  <= 1'b0;
      end else if (line_reset) begin
         state_q  <= IDLE;
         fb_we_q  <= 1'b0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               fb_we_q <= 1'b0;
               if (start) begin
                  state_q <= DRAW;
                  busy_q  <= 1'b1;
               end
            end
            DRAW: begin
               // Off-screen points still take their cycle, just without a write
               fb_we_q   <= on_screen;
               fb_addr_q <= pix_addr;
               fb_data_q <= color_q;
               if (at_end) state_q <= DONE;
            end
            DONE: begin
               fb_we_q  <= 1'b0;
               busy_q   <= 1'b0;
               finish_q <= 1'b1;
               if (start) begin
                  state_q  <= DRAW;
                  busy_q   <= 1'b1;
                  finish_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= IDLE;
               fb_we_q  <= 1'b0;
               busy_q   <= 1'b0;
               finish_q <= 1'b0;
            end
         endcase
      end
   end

   assign fb_we   = fb_we_q;
   assign fb_addr = fb_addr_q;
   assign fb_data = fb_data_q;
   assign busy    = busy_q;
   assign finish  = finish_q;

endmodule : line_raster_engine

// File: tb/tb_line_raster_engine.sv
// Scoreboard bench for line_raster_engine: a plain-integer Bresenham model
// predicts every framebuffer write (cycle, address, data); a negedge monitor
// pops and compares whenever fb_we is seen.
module tb_line_raster_engine;

   localparam int unsigned CW = pm_gfx_pkg::COORD_W;
   localparam int unsigned AW = pm_gfx_pkg::ADDR_W;
   localparam int unsigned DW = pm_gfx_pkg::COLOR_W;
   localparam int          W  = 320;
   localparam int          H  = 240;

   logic          clk = 1'b0;
   logic          reset;
   logic          line_reset;
   logic          start;
   logic [CW-1:0] x0, y0, x1, y1;
   logic [DW-1:0] color;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_data;
   logic          busy;
   logic          finish;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } exp_t;

   exp_t exp_q[$];
   int   mdl_x[$];
   int   mdl_y[$];
   int   fixed_q[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   line_raster_engine dut (
      .clk        (clk),
      .reset      (reset),
      .line_reset (line_reset),
      .start      (start),
      .x0         (x0),
      .y0         (y0),
      .x1         (x1),
      .y1         (y1),
      .color      (color),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .busy       (busy),
      .finish     (finish)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every presented write must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t ex;
      if (!reset && fb_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_we", int'(fb_addr), -1);
         end else begin
            ex = exp_q.pop_front();
            chk("we_cycle", cyc, ex.cyc);
            chk("we_addr", int'(fb_addr), ex.addr);
            chk("we_data", int'(fb_data), ex.data);
         end
      end
   end

   // Reference line: classic integer Bresenham, all pixels from start to end
   task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1);
      int x, y, dx, dy, sx, sy, err, e2;
      x   = ax0;
      y   = ay0;
      dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
      sx  = (ax1 >= ax0) ? 1 : -1;
      sy  = (ay1 >= ay0) ? 1 : -1;
      err = dx + dy;
      mdl_x.delete();
      mdl_y.delete();
      for (int k = 0; k < 4096; k++) begin
         mdl_x.push_back(x);
         mdl_y.push_back(y);
         if (x == ax1 && y == ay1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endtask

   task automatic set_fixed4(input int a0, input int a1, input int a2, input int a3);
      fixed_q.delete();
      fixed_q.push_back(a0);
      fixed_q.push_back(a1);
      fixed_q.push_back(a2);
      fixed_q.push_back(a3);
   endtask

   // Issue one command. abort_at < 0: run to completion; otherwise abort in
   // that relative cycle with line_reset (hard=0) or the async reset (hard=1).
   // fixed_q, when loaded, supplies literal expected addresses (-1 = clipped).
   task automatic draw(input int ax0, input int ay0, input int ax1, input int ay1,
                       input int col, input int abort_at, input bit hard);
      int   n, e, lim, a;
      exp_t ex;
      model_line(ax0, ay0, ax1, ay1);
      n   = (fixed_q.size() > 0) ? fixed_q.size() : mdl_x.size();
      e   = cyc + 1;
      lim = (abort_at < 0) ? n : (hard ? abort_at - 1 : abort_at);
      if (lim > n) lim = n;
      for (int i = 0; i < lim; i++) begin
         if (fixed_q.size() > 0) a = fixed_q[i];
         else if (mdl_x[i] < W && mdl_y[i] < H) a = mdl_y[i] * W + mdl_x[i];
         else a = -1;
         if (a >= 0) begin
            ex.cyc  = e + i + 1;
            ex.addr = a;
            ex.data = col;
            exp_q.push_back(ex);
         end
      end
      fixed_q.delete();

      x0    = CW'(ax0);
      y0    = CW'(ay0);
      x1    = CW'(ax1);
      y1    = CW'(ay1);
      color = DW'(col);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_c0", int'(busy), 1);
      chk("finish_c0", int'(finish), 0);

      if (abort_at < 0) begin
         repeat (n) begin @(posedge clk); #1; end
         chk("busy_last", int'(busy), 1);
         chk("finish_last", int'(finish), 0);
         @(posedge clk); #1;
         chk("finish_hi", int'(finish), 1);
         chk("busy_lo", int'(busy), 0);
         chk("we_at_finish", int'(fb_we), 0);
         chk("pending", exp_q.size(), 0);
      end else begin
         repeat (abort_at) begin @(posedge clk); #1; end
         if (hard) begin
            reset = 1'b1;
            #1;
            chk("rst_we", int'(fb_we), 0);
            chk("rst_addr", int'(fb_addr), 0);
            chk("rst_data", int'(fb_data), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_finish", int'(finish), 0);
            @(posedge clk); #1;
            reset = 1'b0;
         end else begin
            line_reset = 1'b1;
            @(posedge clk); #1;
            line_reset = 1'b0;
         end
         chk("abort_busy", int'(busy), 0);
         chk("abort_finish", int'(finish), 0);
         chk("abort_we", int'(fb_we), 0);
         chk("abort_pending", exp_q.size(), 0);
      end
   endtask

   // Watchdog so the run always ends
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int ax0, ay0, ax1, ay1;
      reset      = 1'b1;
      line_reset = 1'b0;
      start      = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      color = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_we", int'(fb_we), 0);
      chk("reset_addr", int'(fb_addr), 0);
      chk("reset_data", int'(fb_data), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_finish", int'(finish), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      set_fixed4(0, 1, 2, 3);
      draw(0, 0, 3, 0, 'hE0, -1, 1'b0);
      fixed_q.push_back(1605);
      draw(5, 5, 5, 5, 'h11, -1, 1'b0);
      set_fixed4(963, 642, 321, 0);
      draw(3, 3, 0, 0, 'h22, -1, 1'b0);
      set_fixed4(0, 320, 641, 961);
      draw(0, 0, 1, 3, 'h44, -1, 1'b0);
      set_fixed4(318, 319, -1, -1);
      draw(318, 0, 321, 0, 'h99, -1, 1'b0);

      draw(0, 0, 9, 0, 'h5A, 3, 1'b0);
      draw(2, 1, 6, 4, 'h33, -1, 1'b0);
      draw(0, 0, 9, 0, 'h77, 3, 1'b1);
      draw(7, 2, 1, 9, 'hC3, -1, 1'b0);
      draw(319, 239, 330, 250, 'h0F, -1, 1'b0);

      for (int t = 0; t < 30; t++) begin
         ax0 = int'($urandom_range(0, 400));
         ay0 = int'($urandom_range(0, 300));
         if (t % 2 == 0) begin
            ax1 = ax0 + int'($urandom_range(0, 16)) - 8;
            ay1 = ay0 + int'($urandom_range(0, 16)) - 8;
            if (ax1 < 0) ax1 = 0;
            if (ay1 < 0) ay1 = 0;
         end else begin
            ax1 = int'($urandom_range(0, 400));
            ay1 = int'($urandom_range(0, 300));
         end
         draw(ax0, ay0, ax1, ay1, int'($urandom_range(0, 255)), -1, 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("drain", exp_q.size(), 0);
      chk("idle_finish", int'(finish), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_line_raster_engine
